// File: rtl/recip_pkg.sv
// Shared widths, constants and FSM encoding for the softmax reciprocal unit.
package recip_pkg;

    localparam int unsigned DATA_W  = 18;
    localparam int unsigned RECIP_W = 36;
    localparam int unsigned REM_W   = 19;

    localparam logic [RECIP_W-1:0] DIVIDEND  = 36'h8_0000_0000;
    localparam logic [RECIP_W-1:0] RECIP_SAT = 36'hF_FFFF_FFFF;

    typedef enum logic [0:0] {IDLE, CALC} state_e;

endpackage

// File: rtl/recip_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract
// the divisor when it fits and report the resulting quotient bit.
module recip_div_step
    import recip_pkg::*;
(
    input  logic [REM_W-1:0]  rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [REM_W-1:0]  rem_out,
    output logic              q_bit
);

    logic [REM_W:0] wide;

    always_comb begin
        wide    = {rem_in, dividend_bit};
        q_bit   = (wide >= {2'b00, divisor});
        rem_out = q_bit ? REM_W'(wide - {2'b00, divisor}) : wide[REM_W-1:0];
    end

endmodule

// File: rtl/softmax_reciprocal.sv
// Iterative restoring divider producing 2^35 / i_data (Q11.7 in, Q8.28 out).
// Define RECIP_ROUND_EN to round to nearest instead of truncating.
module softmax_reciprocal
    import recip_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_busy,
    output logic               o_valid,
    output logic [RECIP_W-1:0] o_recip
);

    localparam int unsigned STEPS = RECIP_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RECIP_W-1:0]  dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [RECIP_W-1:0]  quot_q, quot_d;
    logic [RECIP_W-1:0]  recip_q, recip_d;
    logic                valid_q, valid_d;

    logic [RECIP_W-1:0]        dividend_load;
    logic [RECIP_W-1:0]        quot_next;
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [REM_W-1:0]          rem_chain [BITS_PER_CYCLE+1];

`ifdef RECIP_ROUND_EN
    assign dividend_load = DIVIDEND + RECIP_W'(i_data >> 1);
`else
    assign dividend_load = DIVIDEND;
`endif

    // Dividend is consumed MSB-first; step k uses the k-th bit below the top.
    assign rem_chain[0] = rem_q;
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        recip_div_step u_step (
            .rem_in       (rem_chain[k]),
            .dividend_bit (dividend_q[RECIP_W-1-k]),
            .divisor      (divisor_q),
            .rem_out      (rem_chain[k+1]),
            .q_bit        (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    assign quot_next = (quot_q << BITS_PER_CYCLE) | RECIP_W'(q_bits);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        recip_d    = recip_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    divisor_d  = i_data;
                    dividend_d = dividend_load;
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = STEPS_C;
                    state_d    = CALC;
                end
            end
            CALC: begin
                dividend_d = dividend_q << BITS_PER_CYCLE;
                rem_d      = rem_chain[BITS_PER_CYCLE];
                quot_d     = quot_next;
                cnt_d      = cnt_q - LAST_C;
                if (cnt_q == LAST_C) begin
                    recip_d = (divisor_q == '0) ? RECIP_SAT : quot_next;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            recip_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            recip_q    <= recip_d;
            valid_q    <= valid_d;
        end
    end

    assign o_busy  = (state_q == CALC);
    assign o_valid = valid_q;
    assign o_recip = recip_q;

endmodule

// File: tb/tb_softmax_reciprocal.sv
// Randomised bench for softmax_reciprocal against an arithmetic reciprocal model.
// Honours RECIP_ROUND_EN the same way as the design.
module tb_softmax_reciprocal;

    localparam int unsigned BPC   = 4;
    localparam int unsigned STEPS = 36 / BPC;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b1;
    logic        i_valid = 1'b0;
    logic [17:0] i_data  = '0;
    logic        o_busy;
    logic        o_valid;
    logic [35:0] o_recip;

    int vectors     = 0;
    int miscompares = 0;

    softmax_reciprocal #(
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_recip (o_recip)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [35:0] ref_recip(input logic [17:0] d);
        longint unsigned num;
        longint unsigned den;
        if (d == 18'd0) return 36'hF_FFFF_FFFF;
        den = 64'(d);
        num = 64'd1 << 35;
`ifdef RECIP_ROUND_EN
        num = num + den / 2;
`endif
        return 36'(num / den);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the o_valid cycle.
    task automatic do_op(input logic [17:0] d, input bit inject);
        int          n;
        bit          got;
        logic [35:0] exp;
        exp     = ref_recip(d);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_data  = 18'($urandom);
        n   = 0;
        got = 1'b0;
        while (!got && n < STEPS + 4) begin
            @(negedge i_clk);
            n++;
            if (n == 1) check_eq($sformatf("busy_start d=%0h", d), 64'(o_busy), 64'd1);
            if (inject && n == 3) begin
                i_valid = 1'b1;
                i_data  = 18'd8;
            end else begin
                i_valid = 1'b0;
            end
            got = (o_valid === 1'b1);
        end
        check_eq($sformatf("latency d=%0h", d), 64'(n), 64'(STEPS + 1));
        check_eq($sformatf("recip d=%0h", d), 64'(o_recip), 64'(exp));
        check_eq($sformatf("busy_end d=%0h", d), 64'(o_busy), 64'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) seen++;
        end
        check_eq(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [17:0] d;

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("rst_recip", 64'(o_recip), 64'd0);
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);

        do_op(18'd4, 1'b0);
        check_eq("tp_d4", 64'(o_recip), 64'h2_0000_0000);
        @(negedge i_clk);
        check_eq("pulse_width", 64'(o_valid), 64'd0);
        check_eq("recip_hold", 64'(o_recip), 64'h2_0000_0000);

        do_op(18'd1, 1'b0);
        check_eq("tp_d1", 64'(o_recip), 64'h8_0000_0000);
        do_op(18'd3, 1'b0);
`ifdef RECIP_ROUND_EN
        check_eq("tp_d3", 64'(o_recip), 64'h2_AAAA_AAAB);
`else
        check_eq("tp_d3", 64'(o_recip), 64'h2_AAAA_AAAA);
`endif
        do_op(18'h3FFFF, 1'b0);
`ifdef RECIP_ROUND_EN
        check_eq("tp_dmax", 64'(o_recip), 64'h0_0002_0001);
`else
        check_eq("tp_dmax", 64'(o_recip), 64'h0_0002_0000);
`endif

        do_op(18'd0, 1'b1);
        check_eq("tp_d0_sat", 64'(o_recip), 64'hF_FFFF_FFFF);
        watch_quiet("busy_req_ignored", 12);
        do_op(18'd8, 1'b0);
        check_eq("tp_d8", 64'(o_recip), 64'h1_0000_0000);

        // Abort mid-calculation with reset in the fourth CALC cycle.
        i_valid = 1'b1;
        i_data  = 18'd5;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("abort_valid", 64'(o_valid), 64'd0);
        check_eq("abort_recip", 64'(o_recip), 64'd0);
        check_eq("abort_busy", 64'(o_busy), 64'd0);
        watch_quiet("abort_no_result", 12);
        do_op(18'd2, 1'b0);
        check_eq("tp_d2", 64'(o_recip), 64'h4_0000_0000);

        // Randomised back-to-back operations.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) d = 18'($urandom_range(0, 15));
            else            d = 18'($urandom_range(0, 262143));
            do_op(d, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
